cr_kme_beat_serializer: RTL and testbench
=========================================

# cr_kme_beat_serializer

Downstream drain stage for the KME 611-bit entry FIFO. It pops one wide entry at a time over the FIFO's valid/ack read handshake, holds it in a capture register and emits it as a train of 64-bit beats on a valid/ready stream with start/end-of-packet markers. Back-to-back entries stream with no bubble beat.

## Interface
Parameters:
- IN_W, 611, width of one FIFO entry
- OUT_W, 64, output beat width
- NBEATS, ceil(IN_W/OUT_W) = 10, beats per entry (derived, not overridable)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  IN_W  FIFO read data (fifo_out)
- in_valid  in  1  FIFO non-empty (fifo_out_valid)
- in_ack  out  1  pop strobe to FIFO (fifo_out_ack); one-cycle pulse per consumed entry
- out_data  out  OUT_W  current beat
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_sop  out  1  beat 0 of entry
- out_eop  out  1  beat NBEATS-1 of entry
- out_beat_idx  out  4  index of current beat, 0..NBEATS-1
- word_cnt  out  16  count of entries fully emitted, wraps 0xFFFF->0
- out_par  out  1  even parity of out_data (only with CR_KME_SER_PARITY_EN)

## Operation
- States: IDLE (capture register empty), SEND (register holds entry, emitting beats).
- IDLE: if in_valid, capture in_data, assert in_ack that cycle, go SEND with beat_idx=0. Else stay.
- SEND: out_valid=1, out_data = cap[beat_idx*64 +: 64]; bits above IN_W-1 in last beat (out_data[63:35] of beat 9) are zero.
- Beat accepted when out_valid && out_ready: beat_idx increments. Stall (out_ready=0): out_data, out_sop, out_eop, out_beat_idx held stable.
- Last beat accepted: word_cnt increments. If in_valid same cycle, capture next entry, pulse in_ack, stay SEND, beat_idx=0 (no bubble). Else go IDLE.
- in_ack asserted only when in_valid=1; never while a held entry has beats remaining. Never acks the same entry twice.
- out_sop = SEND && beat_idx==0; out_eop = SEND && beat_idx==NBEATS-1.
- Reset: state IDLE, beat_idx 0, capture register 0, word_cnt 0. Reset mid-entry discards remaining beats of the held (already popped) entry; no further beats of it are emitted.
- beat_idx never exceeds NBEATS-1; wraps to 0 only through capture.

## Timing
- Reset values: in_ack 0, out_valid 0, out_data 0, out_sop 0, out_eop 0, out_beat_idx 0, word_cnt 0, out_par 0.
- in_ack is combinational from state and in_valid (and out_ready on last beat); FIFO pops on that edge.
- Latency in_valid rise (IDLE) -> first out_valid: 1 cycle.
- Throughput with out_ready=1 continuous: 1 beat/cycle, one entry per 10 cycles, in_ack every 10th cycle.
- out_valid, out_data, out_sop, out_eop, out_beat_idx driven from registers; no combinational path out_ready -> out_valid/out_data.
- Only combinational input-to-output path: in_valid, out_ready -> in_ack.

## Configuration
- CR_KME_SER_PARITY_EN defined: out_par port present, registered alongside out_data, equals ^out_data of the current beat, 0 when out_valid=0.
- Undefined: out_par port and its logic absent; all other behaviour identical.

## Structure
- Package cr_kme_ser_pkg: IN_W, OUT_W, NBEATS constants, beat-index width, state enum {IDLE, SEND}.
- One sub-module natural: cr_kme_ser_beat_mux, pure combinational slice of the capture register by beat_idx with zero padding of the final beat.
- FSM, counter, capture register and word_cnt in the top module.

## Test plan
- Single entry, in_data bits = bit index parity pattern 0x5555..., out_ready=1: in_ack one pulse, 10 beats, sop on beat 0, eop on beat 9, beat 9 bits[63:35]=0, word_cnt=1.
- Three entries queued, out_ready=1: 30 consecutive valid beats with no gap, in_ack at cycles 0,10,20, word_cnt=3.
- out_ready toggled 1,0,0,1 repeating during one entry: each beat held unchanged while stalled, exactly 10 accepted beats, single in_ack.
- in_valid=0 throughout: in_ack never asserted, out_valid stays 0, word_cnt 0.
- rst asserted at beat 4 of an entry: next cycle out_valid=0, beat_idx 0, word_cnt 0; subsequent entry emits from beat 0 with correct data.
- With CR_KME_SER_PARITY_EN, beat data 0x0000_0000_0000_0007: out_par=1; data 0x3: out_par=0.

Source files
------------

// File: rtl/cr_kme_ser_pkg.sv
// Shared constants and state encoding for the KME entry beat serializer.
package cr_kme_ser_pkg;
  localparam int IN_W   = 611;
  localparam int OUT_W  = 64;
  localparam int NBEATS = (IN_W + OUT_W - 1) / OUT_W;
  localparam int IDX_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;
endpackage

// File: rtl/cr_kme_ser_beat_mux.sv
// Selects one OUT_W beat out of a captured entry; bits past IN_W read as zero.
module cr_kme_ser_beat_mux
  import cr_kme_ser_pkg::*;
#(
  parameter int MUX_IN_W  = IN_W,
  parameter int MUX_OUT_W = OUT_W,
  parameter int MUX_NB    = NBEATS,
  parameter int MUX_IDX_W = IDX_W
) (
  input  logic [MUX_IN_W-1:0]  cap_data,
  input  logic [MUX_IDX_W-1:0] beat_idx,
  output logic [MUX_OUT_W-1:0] beat_data
);
  logic [MUX_NB*MUX_OUT_W-1:0]       flat;
  logic [MUX_NB-1:0][MUX_OUT_W-1:0]  beats;

  always_comb begin
    flat = '0;
    flat[MUX_IN_W-1:0] = cap_data;
  end

  assign beats     = flat;
  assign beat_data = (32'(beat_idx) < MUX_NB) ? beats[beat_idx] : '0;
endmodule

// File: rtl/cr_kme_beat_serializer.sv
// Drains wide KME FIFO entries into a 64-bit valid/ready beat stream with sop/eop.
// Optional CR_KME_SER_PARITY_EN adds a registered even-parity bit out_par.
module cr_kme_beat_serializer #(
  parameter int IN_W  = cr_kme_ser_pkg::IN_W,
  parameter int OUT_W = cr_kme_ser_pkg::OUT_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IN_W-1:0]                   in_data,
  input  logic                              in_valid,
  output logic                              in_ack,
  output logic [OUT_W-1:0]                  out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [cr_kme_ser_pkg::IDX_W-1:0]  out_beat_idx,
`ifdef CR_KME_SER_PARITY_EN
  output logic                              out_par,
`endif
  output logic [15:0]                       word_cnt
);
  import cr_kme_ser_pkg::*;

  localparam int NB = (IN_W + OUT_W - 1) / OUT_W;

  ser_state_e        state;
  logic [IDX_W-1:0]  beat_idx;
  logic [IN_W-1:0]   cap;
  logic [OUT_W-1:0]  data_q;

  logic              accept, last_beat, nxt_send;
  logic [IN_W-1:0]   nxt_cap;
  logic [IDX_W-1:0]  nxt_idx;
  logic [OUT_W-1:0]  nxt_beat;

  assign accept    = (state == SEND) && out_ready;
  assign last_beat = (beat_idx == IDX_W'(NB - 1));
  // Gated by rst so an entry is never popped on an edge where it cannot be captured.
  assign in_ack    = !rst && in_valid && ((state == IDLE) || (accept && last_beat));

  always_comb begin
    nxt_cap  = cap;
    nxt_idx  = beat_idx;
    nxt_send = (state == SEND);
    if (in_ack) begin
      nxt_cap  = in_data;
      nxt_idx  = '0;
      nxt_send = 1'b1;
    end else if (accept) begin
      if (last_beat) begin
        nxt_idx  = '0;
        nxt_send = 1'b0;
      end else begin
        nxt_idx  = beat_idx + IDX_W'(1);
      end
    end
  end

  // Beat data is looked up from next-state so out_data comes straight off a flop.
  cr_kme_ser_beat_mux #(
    .MUX_IN_W (IN_W),
    .MUX_OUT_W(OUT_W),
    .MUX_NB   (NB),
    .MUX_IDX_W(IDX_W)
  ) u_mux (
    .cap_data (nxt_cap),
    .beat_idx (nxt_idx),
    .beat_data(nxt_beat)
  );

`ifdef CR_KME_SER_PARITY_EN
  logic par_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_idx <= '0;
      cap      <= '0;
      data_q   <= '0;
      word_cnt <= '0;
`ifdef CR_KME_SER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= nxt_send ? SEND : IDLE;
      beat_idx <= nxt_idx;
      cap      <= nxt_cap;
      data_q   <= nxt_send ? nxt_beat : '0;
      if (accept && last_beat)
        word_cnt <= word_cnt + 16'd1;
`ifdef CR_KME_SER_PARITY_EN
      par_q    <= nxt_send ? ^nxt_beat : 1'b0;
`endif
    end
  end

  assign out_valid    = (state == SEND);
  assign out_data     = data_q;
  assign out_sop      = out_valid && (beat_idx == '0);
  assign out_eop      = out_valid && last_beat;
  assign out_beat_idx = beat_idx;
`ifdef CR_KME_SER_PARITY_EN
  assign out_par      = par_q;
`endif
endmodule

// File: tb/tb_cr_kme_beat_serializer.sv
// Scoreboard bench for cr_kme_beat_serializer: a FIFO model feeds entries, a monitor checks beats.
module tb_cr_kme_beat_serializer;
  import cr_kme_ser_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ack;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_sop, out_eop;
  logic [IDX_W-1:0]  out_beat_idx;
  logic [15:0]       word_cnt;
`ifdef CR_KME_SER_PARITY_EN
  logic              out_par;
`endif

  cr_kme_beat_serializer dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_beat_idx(out_beat_idx),
`ifdef CR_KME_SER_PARITY_EN
    .out_par(out_par),
`endif
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [3:0]  idx;
  } beat_t;

  beat_t           exp_q[$];
  logic [IN_W-1:0] fifo[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, ack_cnt = 0, acc_cnt = 0;
  int ack_cyc[$];
  bit pop_pending = 0;
  bit held_v = 0;
  beat_t held;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO model: pop on the edge that saw in_ack, then present the new head.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_pending && fifo.size() > 0) fifo.delete(0);
    pop_pending = 0;
    in_valid = (fifo.size() > 0);
    in_data  = in_valid ? fifo[0] : '0;
  end

  always @(negedge clk) begin
    beat_t cur, e;
    cur.data = out_data; cur.sop = out_sop; cur.eop = out_eop; cur.idx = out_beat_idx;
    if (in_ack) begin
      pop_pending = 1;
      ack_cnt++;
      ack_cyc.push_back(cyc);
    end
    if (rst) held_v = 0;
    else begin
      if (held_v) check("stall_hold", {9'd0, out_valid, cur}, {9'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got %h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
`ifdef CR_KME_SER_PARITY_EN
          check("parity", 80'(out_par), 80'(^e.data));
`endif
        end
      end
      held_v = out_valid && !out_ready;
      held   = cur;
    end
  end

  function automatic logic [63:0] tag_beat(input logic [7:0] tag, input int k);
    logic [63:0] b;
    b = {tag, 8'(k), 48'h0123_4567_89AB};
    if (k == 9) b = b & 64'h0000_0007_FFFF_FFFF;
    return b;
  endfunction

  task automatic push_exp(input logic [63:0] d, input int k);
    beat_t b;
    b.data = d; b.sop = (k == 0); b.eop = (k == 9); b.idx = 4'(k);
    exp_q.push_back(b);
  endtask

  task automatic push_tag(input logic [7:0] tag);
    logic [10*64-1:0] w;
    for (int k = 0; k < 10; k++) begin
      w[k*64 +: 64] = {tag, 8'(k), 48'h0123_4567_89AB};
      push_exp(tag_beat(tag, k), k);
    end
    fifo.push_back(w[IN_W-1:0]);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo.size() == 0 && !out_valid) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
  endtask

  initial begin
    int a0, c0, gaps, viol;
    logic [IN_W-1:0] d;
    bit done;

    repeat (3) @(negedge clk);
    check("rst_outs", {out_valid, out_sop, out_eop, in_ack, out_beat_idx, out_data},
          {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0});
    check("rst_word_cnt", 80'(word_cnt), 80'd0);
`ifdef CR_KME_SER_PARITY_EN
    check("rst_par", 80'(out_par), 80'd0);
`endif
    rst = 0;

    // idle: no entries offered
    viol = 0;
    repeat (12) begin
      @(negedge clk);
      if (in_ack || out_valid) viol++;
    end
    check("idle_quiet", 80'(viol), 80'd0);
    check("idle_word_cnt", 80'(word_cnt), 80'd0);

    // single 0x5555 pattern entry
    a0 = ack_cnt;
    for (int i = 0; i < IN_W; i++) d[i] = ~i[0];
    fifo.push_back(d);
    for (int k = 0; k < 9; k++) push_exp(64'h5555_5555_5555_5555, k);
    push_exp(64'h0000_0005_5555_5555, 9);
    wait_drain("single");
    check("single_acks", 80'(ack_cnt - a0), 80'd1);
    check("single_word_cnt", 80'(word_cnt), 80'd1);

    // three entries back to back
    a0 = ack_cnt;
    ack_cyc.delete();
    push_tag(8'hA1); push_tag(8'hA2); push_tag(8'hA3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    gaps = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (!out_valid) gaps++;
    end
    check("no_bubble", 80'(gaps), 80'd0);
    wait_drain("burst");
    check("burst_acks", 80'(ack_cnt - a0), 80'd3);
    if (ack_cyc.size() == 3) begin
      check("ack_spacing_1", 80'(ack_cyc[1] - ack_cyc[0]), 80'd10);
      check("ack_spacing_2", 80'(ack_cyc[2] - ack_cyc[1]), 80'd10);
    end
    check("burst_word_cnt", 80'(word_cnt), 80'd4);

    // backpressure 1,0,0,1
    a0 = ack_cnt; c0 = acc_cnt; done = 0;
    push_tag(8'hB0);
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #2;
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      done = (exp_q.size() == 0 && fifo.size() == 0 && !out_valid);
    end
    out_ready = 1;
    check("stall_done", 80'(done), 80'd1);
    check("stall_accepts", 80'(acc_cnt - c0), 80'd10);
    check("stall_acks", 80'(ack_cnt - a0), 80'd1);
    check("stall_word_cnt", 80'(word_cnt), 80'd5);

    // reset in the middle of an entry
    push_tag(8'hC0);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = out_valid && (out_beat_idx == 4'd4);
    end
    check("reach_beat4", 80'(done), 80'd1);
    rst = 1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_outs", {out_valid, out_beat_idx, word_cnt}, {1'b0, 4'd0, 16'd0});
    rst = 0;
    push_tag(8'hD0);
    wait_drain("after_rst");
    check("after_rst_word_cnt", 80'(word_cnt), 80'd1);

    // low beats 0x7 then 0x3 (odd/even parity)
    d = '0;
    d[63:0]   = 64'h7;
    d[127:64] = 64'h3;
    fifo.push_back(d);
    push_exp(64'h7, 0);
    push_exp(64'h3, 1);
    for (int k = 2; k < 10; k++) push_exp(64'h0, k);
    wait_drain("parity");
    check("parity_word_cnt", 80'(word_cnt), 80'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
